// File: rtl/fakeram_512x64_arb.sv
// ---------------------------------------------------------------------------
// fakeram_512x64_arb
//
// Two-port round-robin front end for a single-port 512x64 SRAM macro.
// Each cycle at most one of the two request ports (A = index 0, B = index 1)
// is granted. The granted request is driven straight onto the macro pins in
// the same cycle. A granted read returns its data one cycle later on the
// shared rd_o bus, tagged by rv_o. Writes produce no response.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   v_i[1:0]     per-port request valid
//   we_i[1:0]    per-port write enable (1 = write, 0 = read)
//   addr_i       {addr_B, addr_A}, ADDR_WIDTH bits each
//   wd_i         {wd_B, wd_A}, BITS bits each
//   wmsk_i       {wmsk_B, wmsk_A}, bit = 1 writes that bit
//   ready_o[1:0] per-port grant (one-hot or zero), combinational
//   rv_o[1:0]    per-port read-response valid
//   rd_o         shared read data, zero whenever rv_o == 0
//   ram_ce_o     macro chip enable (active-high)
//   ram_we_o     macro write enable (active-high)
//   ram_addr_o   macro word address
//   ram_wd_o     macro write data
//   ram_wmsk_o   macro write mask
//   ram_rd_i     macro read data, valid one cycle after a read ce
//   stat_o       {conflicts[15:0], grants_b[15:0], grants_a[15:0]}
//
// Configuration
//   FAKERAM_ARB_STATS_EN  when defined, stat_o carries three saturating
//                         16-bit counters; otherwise stat_o is tied to 0 and
//                         no counter flops exist.
// ---------------------------------------------------------------------------
module fakeram_512x64_arb #(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [1:0]              v_i,
    input  logic [1:0]              we_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [2*BITS-1:0]       wd_i,
    input  logic [2*BITS-1:0]       wmsk_i,
    output logic [1:0]              ready_o,

    output logic [1:0]              rv_o,
    output logic [BITS-1:0]         rd_o,

    output logic                    ram_ce_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [BITS-1:0]         ram_wd_o,
    output logic [BITS-1:0]         ram_wmsk_o,
    input  logic [BITS-1:0]         ram_rd_i,

    output logic [47:0]             stat_o
);

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // last_grant_b is 1 when port B received the most recent grant. It comes
    // out of reset pointing at B so port A wins the first contention.
    logic       last_grant_b;
    logic [1:0] grant;

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first line so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (v_i == 2'b11) begin
                // Contention: the port that did not win last time goes now.
                grant = last_grant_b ? 2'b01 : 2'b10;
            end else begin
                // Zero or one requester: grant exactly what is asking.
                grant = v_i;
            end
        end
    end

    assign ready_o = grant;

    // -----------------------------------------------------------------------
    // Macro request mux: pass the granted port straight through; drive all
    // zeros when nothing is granted so the macro pins are quiet.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_wd_o   = '0;
        ram_wmsk_o = '0;
        if (grant[0]) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = we_i[0];
            ram_addr_o = addr_i[ADDR_WIDTH-1:0];
            ram_wd_o   = wd_i[BITS-1:0];
            ram_wmsk_o = wmsk_i[BITS-1:0];
        end else if (grant[1]) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = we_i[1];
            ram_addr_o = addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
            ram_wd_o   = wd_i[2*BITS-1:BITS];
            ram_wmsk_o = wmsk_i[2*BITS-1:BITS];
        end
    end

    // -----------------------------------------------------------------------
    // Grant history and read-response tracking
    // -----------------------------------------------------------------------
    // rv_q marks which port (if any) was granted a read last cycle; the macro
    // presents that read's data on ram_rd_i this cycle.
    logic [1:0] rv_q;

    // NOTE: clocked state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge values of its neighbours, independent of the
    // order the statements are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_b <= 1'b1;
            rv_q         <= 2'b00;
        end else begin
            // Idle cycles leave the round-robin pointer untouched.
            if (grant != 2'b00) begin
                last_grant_b <= grant[1];
            end
            rv_q <= grant & ~we_i;
        end
    end

    // A read granted in the cycle just before reset has already set rv_q at
    // the edge; masking with reset keeps that response from escaping while
    // reset is high (the flop itself clears at the next edge).
    assign rv_o = rv_q & {2{~reset}};
    assign rd_o = (rv_o != 2'b00) ? ram_rd_i : '0;

    // -----------------------------------------------------------------------
    // Optional statistics
    // -----------------------------------------------------------------------
`ifdef FAKERAM_ARB_STATS_EN
    logic [15:0] grants_a;
    logic [15:0] grants_b;
    logic [15:0] conflicts;

    // All three counters stick at 16'hFFFF rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            grants_a  <= '0;
            grants_b  <= '0;
            conflicts <= '0;
        end else begin
            if (grant[0] && (grants_a != 16'hFFFF)) begin
                grants_a <= grants_a + 16'd1;
            end
            if (grant[1] && (grants_b != 16'hFFFF)) begin
                grants_b <= grants_b + 16'd1;
            end
            if ((v_i == 2'b11) && (conflicts != 16'hFFFF)) begin
                conflicts <= conflicts + 16'd1;
            end
        end
    end

    // Counters clear at the first reset edge; the mask makes stat_o read 0
    // for the whole reset window, including the cycle before that edge.
    assign stat_o = reset ? 48'd0 : {conflicts, grants_b, grants_a};
`else
    assign stat_o = 48'd0;
`endif

endmodule

// File: doc/fakeram_512x64_arb.md
FAKERAM_512X64_ARB -- requirements
Module: fakeram_512x64_arb

Interface
REQ-001 Parameter BITS, default 64, data word and write-mask width.
REQ-002 Parameter ADDR_WIDTH, default 9, word address width (512 words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 v_i  input  2  per-port request valid (index 0 = port A, 1 = port B).
REQ-006 we_i  input  2  per-port write enable (1 = write, 0 = read).
REQ-007 addr_i  input  2*ADDR_WIDTH  per-port word address; port p occupies slice p.
REQ-008 wd_i  input  2*BITS  per-port write data.
REQ-009 wmsk_i  input  2*BITS  per-port write mask; bit = 1 writes that bit.
REQ-010 ready_o  output  2  per-port grant; request accepted when v_i[p] & ready_o[p].
REQ-011 rv_o  output  2  per-port read-response valid.
REQ-012 rd_o  output  BITS  read-response data shared by both ports, qualified by rv_o.
REQ-013 ram_ce_o, ram_we_o  output  1 each  macro chip enable and write enable, active-high.
REQ-014 ram_addr_o  output  ADDR_WIDTH; ram_wd_o, ram_wmsk_o  output  BITS  macro address, data, mask.
REQ-015 ram_rd_i  input  BITS  macro read data, valid one cycle after a read ce.
REQ-016 stat_o  output  48  statistics {conflicts[15:0], grantsB[15:0], grantsA[15:0]}.

Function
REQ-017 At most one ready_o bit SHALL be high per cycle; ready_o is combinational from v_i and the last-grant register.
REQ-018 One port valid -> that port granted the same cycle.
REQ-019 Both valid -> grant goes to the port not granted most recently (round-robin); the loser holds its request.
REQ-020 A port with v_i low SHALL never see ready_o high.
REQ-021 The last-grant register SHALL update only on cycles with a grant.
REQ-022 Grant cycle: ram_ce_o = 1; ram_we_o, ram_addr_o, ram_wd_o, ram_wmsk_o pass through from the granted port in the same cycle.
REQ-023 No grant: ram_ce_o = 0, ram_we_o = 0, other ram outputs 0.
REQ-024 Read granted in cycle N -> rv_o[p] = 1 in cycle N+1 only, rd_o = ram_rd_i.
REQ-025 Writes produce no response.
REQ-026 Response path SHALL NOT back-pressure; one request per cycle is sustained, and a read on one port in N and a read on the other in N+1 return in N+1 and N+2.
REQ-027 rd_o SHALL be 0 when rv_o == 0.
REQ-028 Back-to-back write then read of the same address SHALL return the written data (macro ordering); no forwarding logic.

Reset
REQ-029 With reset high: ready_o = 0, ram_ce_o = 0, rv_o = 0, rd_o = 0, stat_o = 0, no grants.
REQ-030 On release the last-grant register SHALL indicate port B, so port A wins the first contention.
REQ-031 A read granted in cycle N with reset high in N+1 SHALL NOT produce rv_o.

Configuration
REQ-032 Macro FAKERAM_ARB_STATS_EN: when defined, grantsA and grantsB count grants per port and conflicts counts cycles with both v_i high; all three are 16-bit, saturate at 0xFFFF, and clear on reset.
REQ-033 Without FAKERAM_ARB_STATS_EN, stat_o SHALL be tied to 0 and no counter flops are instantiated.

Verification
REQ-034 Reset, then A write addr 0x005 data 0x0123456789ABCDEF mask all-ones, then A read 0x005 -> rv_o = 01 one cycle after the read grant, rd_o = 0x0123456789ABCDEF.
REQ-035 Both ports read continuously for 4 cycles after reset -> grants A,B,A,B; with stats enabled stat_o = {16'd4, 16'd2, 16'd2}.
REQ-036 Write 0xFFFF...FF, then write 0x0 with mask 0x00000000FFFFFFFF to the same address, then read -> rd_o = 0xFFFFFFFF00000000.
REQ-037 Read granted, reset asserted the next cycle -> rv_o stays 0 and all outputs are 0 while in reset.
REQ-038 Only B valid for 3 cycles, then both valid -> B granted 3 times, then A wins the contention.
REQ-039 With stats enabled, 70000 cycles of dual contention -> conflicts saturates at 0xFFFF and does not wrap.
